reconfig_controller: RTL and testbench
======================================

Name: reconfig_controller

Overview:
- Sequences associativity reconfiguration of the mutative cache. It accepts upscale/downscale requests from the associativity predictor over the setup_valid/setup_ready handshake.
- On each accepted request it stalls CPU traffic, drains the in-flight cache transaction, sweeps every line for writeback, invalidates the arrays, then commits the new setup.
- Sits between the predictor, the cache control FSM and the tag/data arrays; it is the sole owner of the setup register.

Parameters:
- SET_SIZE, 16, number of sets (power of two).
- WAYS, 4, number of ways (power of two).
- SETUP_MAX, 3, highest legal setup encoding.
- CNT_W, 16, width of the reconfiguration event counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- setup_valid  input  1  predictor request pending; held high until setup_ready.
- setup_update  input  1  direction: 1 = upscale (setup+1), 0 = downscale (setup-1); stable while setup_valid.
- setup_ready  output  1  one-cycle handshake completion.
- setup  output  2  current associativity configuration, 0..SETUP_MAX.
- cache_busy  input  1  cache FSM has a transaction in flight.
- stall  output  1  cache must not accept new cpu_req.
- flush_req  output  1  request writeback/check of one line.
- flush_set  output  $clog2(SET_SIZE)  set index of the flush line.
- flush_way  output  $clog2(WAYS)  way index of the flush line.
- flush_ready  input  1  line handled (written back, or clean/invalid); may be high the same cycle as flush_req.
- inval_all  output  1  one-cycle pulse clearing all valid/dirty bits.
- reconfig_count  output  CNT_W  number of committed reconfigurations, saturating.

Behaviour:
- Reset values (asynchronous): state IDLE, setup=0, line counter=0, reconfig_count=0.
- Reset values of derived outputs: setup_ready, stall, flush_req, inval_all all 0; flush_set and flush_way 0.
- Reset mid-operation: sequence abandoned, no commit. Lines already flushed stay flushed.
- States: IDLE, DRAIN, FLUSH, INVAL, COMMIT. All outputs are decoded from registered state and counter only, so there are no combinational input-to-output paths except setup_ready in IDLE.
- stall = (state != IDLE).
- IDLE transitions when setup_valid=1:
  - Legal request (update=1 and setup<SETUP_MAX, or update=0 and setup>0): latch direction, go to DRAIN.
  - Illegal request: setup_ready=1 combinationally that cycle (drop), setup unchanged, stay in IDLE.
- Simultaneous setup_valid and cpu_req in IDLE: the cpu_req is accepted by the cache (stall still 0). DRAIN then waits for it.
- DRAIN: stay while cache_busy=1. When cache_busy=0, clear the line counter and go to FLUSH next cycle.
- FLUSH: flush_req=1.
  - flush_set = counter >> log2(WAYS); flush_way = counter[log2(WAYS)-1:0]. This is a set-major sweep, counter width log2(SET_SIZE*WAYS).
  - The counter advances only on flush_req & flush_ready.
  - On the last line (counter = SET_SIZE*WAYS-1) with flush_ready=1, go to INVAL. The counter wraps to 0.
  - A line takes a minimum of 1 cycle, so the sweep takes at least SET_SIZE*WAYS cycles.
- INVAL: inval_all=1 for exactly one cycle, then go to COMMIT.
- COMMIT:
  - setup_ready=1 for exactly one cycle.
  - setup <= setup ± 1 at the end of the cycle.
  - reconfig_count increments, holding at all-ones.
  - Then go to IDLE; stall drops in the first IDLE cycle.
- setup_valid dropping before the handshake (protocol violation) does not abort an accepted sequence.
- Minimum accept-to-ready latency: 1 (DRAIN) + SET_SIZE*WAYS (FLUSH) + 1 (INVAL) + 1 (COMMIT) cycles.

Decomposition:
- Shared package mutative_types holds:
  - the reconfig_state_t enum;
  - SETUP_BITS = 2 and SETUP_MAX;
  - SET_SIZE, WAYS and the derived index widths.
- One sub-module is natural: flush_sweeper. It holds the line counter, the set/way split and last-line detection, driven by start/advance inputs.

Test Plan:
- Reset, then setup_valid=1 with update=1 and cache_busy=0, flush_ready tied to 1 → setup_ready after 1+64+1+1=67 cycles (16x4). setup becomes 1, reconfig_count=1, inval_all pulses once.
- setup=0 with a downscale request → setup_ready in the same cycle, stall never asserts, setup stays 0, reconfig_count unchanged.
- Request while cache_busy is held high for 10 cycles → stall=1 throughout, flush_req stays 0 until cache_busy falls, then the sweep starts at set 0 / way 0.
- flush_ready asserted only every 3rd cycle → flush_set/flush_way hold until acknowledged. The sequence (0,0),(0,1),(0,2),(0,3),(1,0)… is covered in full, with no line skipped or repeated.
- Four consecutive upscales from setup=0 → setup reaches 3; the fourth request is dropped immediately and setup stays 3.
- Assert rst during FLUSH at counter=20 → all outputs 0 and setup=0 immediately (asynchronous). A new request then restarts the sweep at line 0.

Source files
------------

// File: rtl/reconfig_controller_pkg.sv
// ----------------------------------------------------------------------------
// mutative_types
// Shared types and geometry constants for the mutative cache reconfiguration
// logic: the controller state encoding, the setup register width/range and the
// cache geometry with its derived index widths.
// ----------------------------------------------------------------------------
package mutative_types;

    // Associativity setup register
    localparam int SETUP_BITS = 2;
    localparam int SETUP_MAX  = 3;

    // Cache geometry (both powers of two, WAYS >= 2)
    localparam int SET_SIZE = 16;
    localparam int WAYS     = 4;
    localparam int SET_W    = $clog2(SET_SIZE);
    localparam int WAY_W    = $clog2(WAYS);
    localparam int LINE_W   = SET_W + WAY_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_INVAL,
        ST_COMMIT
    } reconfig_state_t;

endpackage

// File: rtl/reconfig_controller_sweeper.sv
// ----------------------------------------------------------------------------
// flush_sweeper
// Line counter for the writeback sweep. Walks every line set-major: the low
// WAY_W bits select the way, the upper SET_W bits select the set.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start_i      clear the counter to line 0
//   advance_i    current line acknowledged, step to the next one
//   set_o        set index of the current line
//   way_o        way index of the current line
//   last_o       current line is the final line of the sweep
// ----------------------------------------------------------------------------
module flush_sweeper #(
    parameter int SET_W = 4,
    parameter int WAY_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             advance_i,
    output logic [SET_W-1:0] set_o,
    output logic [WAY_W-1:0] way_o,
    output logic             last_o
);

    localparam int LINE_W = SET_W + WAY_W;

    logic [LINE_W-1:0] line_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (start_i) begin
            line_q <= '0;
        end else if (advance_i) begin
            // Wraps to 0 naturally after the last line.
            line_q <= line_q + 1'b1;
        end
    end

    assign set_o  = line_q[LINE_W-1:WAY_W];
    assign way_o  = line_q[WAY_W-1:0];
    assign last_o = &line_q;

endmodule

// File: rtl/reconfig_controller.sv
// ----------------------------------------------------------------------------
// reconfig_controller
// Sequences an associativity change of the mutative cache: stall the CPU,
// drain the in-flight transaction, sweep every line for writeback, clear all
// valid/dirty bits, then commit the new setup. Sole owner of the setup register.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   setup_valid     predictor request pending (held until setup_ready)
//   setup_update    1 = upscale (setup+1), 0 = downscale (setup-1)
//   setup_ready     one-cycle completion (commit, or immediate drop if illegal)
//   setup           current associativity configuration
//   cache_busy      cache FSM has a transaction in flight
//   stall           cache must not accept new CPU requests
//   flush_req       writeback/check request for line (flush_set, flush_way)
//   flush_ready     current flush line handled
//   inval_all       one-cycle pulse clearing all valid/dirty bits
//   reconfig_count  saturating count of committed reconfigurations
// ----------------------------------------------------------------------------
module reconfig_controller #(
    parameter int SET_SIZE  = mutative_types::SET_SIZE,
    parameter int WAYS      = mutative_types::WAYS,
    parameter int SETUP_MAX = mutative_types::SETUP_MAX,
    parameter int CNT_W     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  setup_valid,
    input  logic                                  setup_update,
    output logic                                  setup_ready,
    output logic [mutative_types::SETUP_BITS-1:0] setup,
    input  logic                                  cache_busy,
    output logic                                  stall,
    output logic                                  flush_req,
    output logic [$clog2(SET_SIZE)-1:0]           flush_set,
    output logic [$clog2(WAYS)-1:0]               flush_way,
    input  logic                                  flush_ready,
    output logic                                  inval_all,
    output logic [CNT_W-1:0]                      reconfig_count
);

    localparam int SB    = mutative_types::SETUP_BITS;
    localparam int SET_W = $clog2(SET_SIZE);
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [SB-1:0] SETUP_TOP = SB'(SETUP_MAX);

    mutative_types::reconfig_state_t state_q;

    logic             dir_q;      // latched direction of the accepted request
    logic [SB-1:0]    setup_q;
    logic [SB-1:0]    setup_d;
    logic [CNT_W-1:0] count_q;

    logic req_legal;
    logic sweep_start;
    logic sweep_advance;
    logic sweep_last;

    // A request is legal only if it keeps setup inside 0..SETUP_MAX.
    assign req_legal = setup_update ? (setup_q < SETUP_TOP) : (setup_q != '0);

    assign setup_d = dir_q ? setup_q + 1'b1 : setup_q - 1'b1;

    // Counter is cleared on the cycle DRAIN sees the cache idle, so FLUSH
    // always opens on set 0 / way 0.
    assign sweep_start   = (state_q == mutative_types::ST_DRAIN) && !cache_busy;
    assign sweep_advance = flush_req && flush_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= mutative_types::ST_IDLE;
            dir_q   <= 1'b0;
            setup_q <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                mutative_types::ST_IDLE: begin
                    // Illegal requests are dropped combinationally via setup_ready.
                    if (setup_valid && req_legal) begin
                        dir_q   <= setup_update;
                        state_q <= mutative_types::ST_DRAIN;
                    end
                end
                mutative_types::ST_DRAIN: begin
                    if (!cache_busy) state_q <= mutative_types::ST_FLUSH;
                end
                mutative_types::ST_FLUSH: begin
                    if (sweep_advance && sweep_last) state_q <= mutative_types::ST_INVAL;
                end
                mutative_types::ST_INVAL: begin
                    state_q <= mutative_types::ST_COMMIT;
                end
                mutative_types::ST_COMMIT: begin
                    setup_q <= setup_d;
                    if (count_q != '1) count_q <= count_q + 1'b1;
                    state_q <= mutative_types::ST_IDLE;
                end
                default: state_q <= mutative_types::ST_IDLE;
            endcase
        end
    end

    flush_sweeper #(
        .SET_W (SET_W),
        .WAY_W (WAY_W)
    ) u_sweeper (
        .clk       (clk),
        .rst       (rst),
        .start_i   (sweep_start),
        .advance_i (sweep_advance),
        .set_o     (flush_set),
        .way_o     (flush_way),
        .last_o    (sweep_last)
    );

    // Outputs decode registered state only; the IDLE drop term is the single
    // input-to-output path.
    assign stall          = (state_q != mutative_types::ST_IDLE);
    assign flush_req      = (state_q == mutative_types::ST_FLUSH);
    assign inval_all      = (state_q == mutative_types::ST_INVAL);
    assign setup_ready    = (state_q == mutative_types::ST_COMMIT) ||
                            ((state_q == mutative_types::ST_IDLE) && setup_valid && !req_legal);
    assign setup          = setup_q;
    assign reconfig_count = count_q;

endmodule

// File: tb/tb_reconfig_controller.sv
module tb_reconfig_controller;

    localparam int SET_SIZE = 16;
    localparam int WAYS     = 4;
    localparam int LINES    = SET_SIZE * WAYS;
    localparam int SMAX     = 3;
    localparam int TIMEOUT  = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        setup_valid;
    logic        setup_update;
    logic        setup_ready;
    logic [1:0]  setup;
    logic        cache_busy;
    logic        stall;
    logic        flush_req;
    logic [3:0]  flush_set;
    logic [1:0]  flush_way;
    logic        flush_ready;
    logic        inval_all;
    logic [15:0] reconfig_count;

    int total = 0;
    int bad   = 0;

    // Abstract model of the committed configuration
    int exp_setup;
    int exp_count;

    typedef struct {
        logic upd;
        int   busy;       // cycles cache_busy is held from the request cycle
        int   ack;        // 0 = random flush_ready, else ack every ack-th cycle
        bit   legal;
        int   exp_setup;
        int   exp_count;
    } vec_t;

    vec_t tbl [9];

    reconfig_controller #(
        .SET_SIZE  (SET_SIZE),
        .WAYS      (WAYS),
        .SETUP_MAX (SMAX),
        .CNT_W     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .setup_valid    (setup_valid),
        .setup_update   (setup_update),
        .setup_ready    (setup_ready),
        .setup          (setup),
        .cache_busy     (cache_busy),
        .stall          (stall),
        .flush_req      (flush_req),
        .flush_set      (flush_set),
        .flush_way      (flush_way),
        .flush_ready    (flush_ready),
        .inval_all      (inval_all),
        .reconfig_count (reconfig_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ack_for(input int mode, input int c);
        if (mode == 0) return logic'($urandom_range(0, 1));
        return (c % mode) == 0;
    endfunction

    // Issue one request and follow it to setup_ready, checking the line walk,
    // stall, inval pulse and latency against the abstract expectations.
    task automatic run_req(input string tag, input logic upd, input int busy_cyc,
                           input int ack_mode, input bit legal, output int lat);
        int  c;
        int  idx;
        int  last_ack;
        int  inval_cnt;
        int  inval_at;
        int  first_flush;
        bit  order_bad;
        bit  stall_bad;
        bit  early_flush;
        bit  done;
        c = 0; idx = 0; last_ack = -1; inval_cnt = 0; inval_at = -1; lat = -1;
        order_bad = 0; stall_bad = 0; early_flush = 0; done = 0;
        first_flush = ((busy_cyc > 1) ? busy_cyc : 1) + 1;

        setup_valid  = 1'b1;
        setup_update = upd;
        cache_busy   = (c < busy_cyc);
        flush_ready  = ack_for(ack_mode, c);
        #1;
        while (!done) begin
            if ((c > 0) !== stall) stall_bad = 1;
            if (inval_all) begin
                inval_cnt++;
                inval_at = c;
            end
            if (flush_req) begin
                if (c < first_flush) early_flush = 1;
                if (idx >= LINES || flush_set !== 4'(idx / WAYS) || flush_way !== 2'(idx % WAYS))
                    order_bad = 1;
                if (flush_ready) begin
                    idx++;
                    last_ack = c;
                end
            end
            if (setup_ready === 1'b1) begin
                lat  = c;
                done = 1;
            end else if (c >= TIMEOUT) begin
                done = 1;
            end
            if (!done) begin
                next_cycle();
                c++;
                cache_busy  = (c < busy_cyc);
                flush_ready = ack_for(ack_mode, c);
                #1;
            end
        end
        next_cycle();
        setup_valid = 1'b0;
        cache_busy  = 1'b0;
        flush_ready = 1'b0;
        #1;

        check({tag, " ready_seen"}, (lat >= 0), 1);
        check({tag, " stall_after"}, stall, 1'b0);
        check({tag, " stall_during"}, stall_bad, 0);
        if (legal) begin
            check({tag, " lines_swept"}, idx, LINES);
            check({tag, " line_order"}, order_bad, 0);
            check({tag, " flush_before_drain"}, early_flush, 0);
            check({tag, " inval_pulses"}, inval_cnt, 1);
            check({tag, " inval_slot"}, inval_at, last_ack + 1);
            check({tag, " latency"}, lat, last_ack + 2);
            if (ack_mode == 1)
                check({tag, " latency_min"}, lat, first_flush + LINES + 1);
        end else begin
            check({tag, " drop_latency"}, lat, 0);
            check({tag, " drop_lines"}, idx, 0);
            check({tag, " drop_inval"}, inval_cnt, 0);
        end
    endtask

    initial begin
        int  lat;
        bit  legal;
        logic upd;
        int  busy;
        int  ack;

        tbl[0] = '{1'b0, 0,  1, 1'b0, 0, 0};
        tbl[1] = '{1'b1, 0,  1, 1'b1, 1, 1};
        tbl[2] = '{1'b1, 10, 1, 1'b1, 2, 2};
        tbl[3] = '{1'b1, 0,  3, 1'b1, 3, 3};
        tbl[4] = '{1'b1, 0,  1, 1'b0, 3, 3};
        tbl[5] = '{1'b0, 3,  0, 1'b1, 2, 4};
        tbl[6] = '{1'b0, 0,  1, 1'b1, 1, 5};
        tbl[7] = '{1'b0, 0,  3, 1'b1, 0, 6};
        tbl[8] = '{1'b0, 0,  1, 1'b0, 0, 6};

        rst = 1'b1; setup_valid = 1'b0; setup_update = 1'b0;
        cache_busy = 1'b0; flush_ready = 1'b0;
        #12;
        check("rst stall", stall, 0);
        check("rst flush_req", flush_req, 0);
        check("rst inval", inval_all, 0);
        check("rst ready", setup_ready, 0);
        check("rst setup", setup, 0);
        check("rst count", reconfig_count, 0);
        check("rst flush_set", flush_set, 0);
        check("rst flush_way", flush_way, 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check("idle stall", stall, 0);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_req($sformatf("vec%0d", i), tbl[i].upd, tbl[i].busy, tbl[i].ack, tbl[i].legal, lat);
            check($sformatf("vec%0d setup", i), setup, tbl[i].exp_setup);
            check($sformatf("vec%0d count", i), reconfig_count, tbl[i].exp_count);
        end

        // Reset in the middle of the sweep
        run_req("pre_rst", 1'b1, 0, 1, 1'b1, lat);
        check("pre_rst setup", setup, 1);
        setup_valid = 1'b1; setup_update = 1'b1; cache_busy = 1'b0; flush_ready = 1'b1;
        for (int k = 0; k < 22; k++) next_cycle();
        #1;
        check("mid flush_req", flush_req, 1);
        check("mid flush_set", flush_set, 5);
        check("mid flush_way", flush_way, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async stall", stall, 0);
        check("async flush_req", flush_req, 0);
        check("async inval", inval_all, 0);
        check("async ready", setup_ready, 0);
        check("async setup", setup, 0);
        check("async count", reconfig_count, 0);
        check("async flush_set", flush_set, 0);
        check("async flush_way", flush_way, 0);
        setup_valid = 1'b0; flush_ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        run_req("post_rst", 1'b1, 0, 1, 1'b1, lat);
        check("post_rst setup", setup, 1);
        check("post_rst count", reconfig_count, 1);

        // Randomised requests against the arithmetic model
        exp_setup = 1;
        exp_count = 1;
        for (int n = 0; n < 20; n++) begin
            upd   = logic'($urandom_range(0, 1));
            busy  = $urandom_range(0, 4);
            ack   = $urandom_range(0, 3);
            legal = upd ? (exp_setup < SMAX) : (exp_setup > 0);
            if (legal) begin
                exp_setup = upd ? exp_setup + 1 : exp_setup - 1;
                exp_count = exp_count + 1;
            end
            run_req($sformatf("rnd%0d", n), upd, busy, ack, legal, lat);
            check($sformatf("rnd%0d setup", n), setup, exp_setup);
            check($sformatf("rnd%0d count", n), reconfig_count, exp_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
